mult_sequencer: RTL and testbench

Multi-cycle MULT/MULTU sequencer that computes a 64-bit HI/LO product by driving the shared MIPS ALU through an iterative shift-add algorithm. It uses only the ALU `ADD` operation with carry-in/carry-out. It sits beside the execute stage, requests the ALU through a req/gnt handshake, and reports completion with a one-cycle `done` pulse. Signed multiplies are handled by two's-complement pre-negation of operands and post-negation of the product, also performed on the ALU.

---
 rtl/mult_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_mult_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: iterative MULT/MULTU engine that borrows the shared ALU
// (ADD with carry only) through a req/gnt handshake. Signed operands are
// pre-negated to magnitudes, and the 64-bit product is post-negated when the
// result sign is negative.
module mult_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout
);

  // ALU control codes, matching includes/alucontrols.v
  localparam logic [3:0] ALU_NOOP = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;

  // Iteration counter wide enough to hold WIDTH-1 (6 bits for WIDTH=32)
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_A,
    S_PRE_B,
    S_ITER,
    S_POST_LO,
    S_POST_HI,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CNT_W-1:0]   r_count;
  logic               r_neg;
  logic               r_carry;

  logic [WIDTH-1:0]   w_mcand_nxt;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_neg_nxt;
  logic               w_carry_nxt;

  assign hi = r_hi;
  assign lo = r_lo;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath next values and combinational ALU drive
  always_comb begin
    w_state_nxt = r_state;
    w_mcand_nxt = r_mcand;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_count_nxt = r_count;
    w_neg_nxt   = r_neg;
    w_carry_nxt = r_carry;
    alu_req     = 1'b0;
    alu_ctl     = ALU_NOOP;
    alu_a       = '0;
    alu_b       = '0;
    alu_cin     = 1'b0;
    busy        = (r_state != S_IDLE);
    done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mcand_nxt = rs;
          w_lo_nxt    = rt;
          w_hi_nxt    = '0;
          w_count_nxt = '0;
          w_neg_nxt   = is_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
          if (is_signed & rs[WIDTH-1]) begin
            w_state_nxt = S_PRE_A;
          end else if (is_signed & rt[WIDTH-1]) begin
            w_state_nxt = S_PRE_B;
          end else begin
            w_state_nxt = S_ITER;
          end
        end
      end

      S_PRE_A: begin
        alu_req = 1'b1;
        alu_a   = ~r_mcand;
        alu_cin = 1'b1;
        if (alu_gnt) begin
          w_mcand_nxt = alu_res;
          // Only signed ops get here, and lo still holds the captured rt
          w_state_nxt = r_lo[WIDTH-1] ? S_PRE_B : S_ITER;
        end
      end

      S_PRE_B: begin
        alu_req = 1'b1;
        alu_a   = ~r_lo;
        alu_cin = 1'b1;
        if (alu_gnt) begin
          w_lo_nxt    = alu_res;
          w_state_nxt = S_ITER;
        end
      end

      S_ITER: begin
        alu_req = 1'b1;
        alu_a   = r_hi;
        alu_b   = r_lo[0] ? r_mcand : '0;
        if (alu_gnt) begin
          {w_hi_nxt, w_lo_nxt} = {alu_cout, alu_res, r_lo[WIDTH-1:1]};
          w_count_nxt          = r_count + CNT_W'(1);
          if (r_count == CNT_W'(WIDTH - 1)) begin
            w_state_nxt = r_neg ? S_POST_LO : S_DONE;
          end
        end
      end

      S_POST_LO: begin
        alu_req = 1'b1;
        alu_a   = ~r_lo;
        alu_cin = 1'b1;
        if (alu_gnt) begin
          w_lo_nxt    = alu_res;
          w_carry_nxt = alu_cout;
          w_state_nxt = S_POST_HI;
        end
      end

      S_POST_HI: begin
        alu_req = 1'b1;
        alu_a   = ~r_hi;
        alu_cin = r_carry;
        if (alu_gnt) begin
          w_hi_nxt    = alu_res;
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (alu_req) begin
      alu_ctl = ALU_ADD;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_mcand <= w_mcand_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_count <= w_count_nxt;
      r_neg   <= w_neg_nxt;
      r_carry <= w_carry_nxt;
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Testbench for mult_sequencer: behavioural ALU, product/latency scoreboard.
module tb_mult_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam logic [3:0] ALU_NOOP = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             is_signed = 1'b0;
  logic [WIDTH-1:0] rs = '0;
  logic [WIDTH-1:0] rt = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             alu_req;
  logic             alu_gnt = 1'b1;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic [WIDTH:0]   w_sum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    int               lat;
  } exp_t;

  exp_t sb[$];

  mult_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .rs        (rs),
    .rt        (rt),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .alu_req   (alu_req),
    .alu_gnt   (alu_gnt),
    .alu_ctl   (alu_ctl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_res   (alu_res),
    .alu_cout  (alu_cout)
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU: adds only when asked for ADD
  assign w_sum = (alu_ctl == ALU_ADD) ?
                 (33'(alu_a) + 33'(alu_b) + 33'(alu_cin)) : 33'h0;
  assign alu_res  = w_sum[WIDTH-1:0];
  assign alu_cout = w_sum[WIDTH];

  // Reference product and grant-always-high latency
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sgn);
    exp_t e;
    logic signed [63:0] xa;
    logic signed [63:0] xb;
    logic [63:0] p;
    logic na;
    logic nb;
    if (sgn) begin
      xa = {{32{a[31]}}, a};
      xb = {{32{b[31]}}, b};
      p  = 64'(xa * xb);
    end else begin
      p = {32'h0, a} * {32'h0, b};
    end
    na = sgn & a[31];
    nb = sgn & b[31];
    e.hi  = p[63:32];
    e.lo  = p[31:0];
    e.lat = 33 + int'(na) + int'(nb) + 2 * int'(na ^ nb);
    return e;
  endfunction

  // Launch one op: start is sampled at the edge after this negedge
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic sgn);
    @(negedge clk);
    rs = a; rt = b; is_signed = sgn; start = 1'b1;
    sb.push_back(model(a, b, sgn));
    @(negedge clk);
    start = 1'b0;
    rs = $urandom; rt = $urandom; is_signed = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) for done; lat counts cycles after the accepting edge
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, alu_req, alu_cin} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got busy/done/req/cin=%b exp 0000", {busy, done, alu_req, alu_cin});
    end
    checks++;
    if ({hi, lo, alu_a, alu_b} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got hi=%h lo=%h a=%h b=%h exp all 0", hi, lo, alu_a, alu_b);
    end
    checks++;
    if (alu_ctl !== ALU_NOOP) begin
      errors++;
      $display("FAIL reset_ctl got %h exp %h", alu_ctl, ALU_NOOP);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Max unsigned product, with a start pulse mid-op that must be ignored
  task automatic test_multu_max();
    exp_t e;
    int lat;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (4) @(negedge clk);
    rs = 32'd3; rt = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat);
    e = sb.pop_front();
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL multu_max_lat got %0d exp %0d", lat, e.lat);
    end
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || {hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL multu_max_prod got %h_%h exp %h_%h", hi, lo, e.hi, e.lo);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL done_pulse got busy/done=%b exp 00", {busy, done});
    end
  endtask

  // Directed signed cases: negative rs, MIN_INT squared, zero with neg=1
  task automatic test_signed();
    logic [31:0] va[3];
    logic [31:0] vb[3];
    exp_t e;
    int lat;
    va[0] = 32'hFFFF_FFFD; vb[0] = 32'd7;
    va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000;
    va[2] = 32'h0;         vb[2] = 32'hFFFF_FFFB;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], 1'b1);
      wait_done(1, lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat) begin
        errors++;
        $display("FAIL signed%0d_lat got %0d exp %0d", i, lat, e.lat);
      end
      checks++;
      if ({hi, lo} !== {e.hi, e.lo}) begin
        errors++;
        $display("FAIL signed%0d_prod got %h_%h exp %h_%h", i, hi, lo, e.hi, e.lo);
      end
      @(negedge clk);
    end
  endtask

  // Grant low on alternate cycles: every stalled edge must hold state
  task automatic test_stall();
    exp_t e;
    int lat;
    int bad;
    logic [31:0] ph;
    logic [31:0] pl;
    bad = 0;
    checks++;
    if (alu_ctl !== ALU_NOOP || alu_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_ctl got ctl=%h req=%b exp %h 0", alu_ctl, alu_req, ALU_NOOP);
    end
    issue(32'd12, 32'd10, 1'b0);
    lat = 1;
    alu_gnt = 1'b0; ph = hi; pl = lo;
    if (alu_req !== 1'b1) bad++;
    while (done !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
      if (!alu_gnt && (hi !== ph || lo !== pl)) bad++;
      if (done !== 1'b1) begin
        alu_gnt = ~alu_gnt;
        ph = hi; pl = lo;
        if (!alu_gnt && alu_req !== 1'b1) bad++;
      end
    end
    e = sb.pop_front();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold got %0d bad stalled cycles exp 0", bad);
    end
    checks++;
    if (lat != 65) begin
      errors++;
      $display("FAIL stall_lat got %0d exp 65", lat);
    end
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || lo !== 32'd120) begin
      errors++;
      $display("FAIL stall_prod got %h_%h exp %h_%h", hi, lo, e.hi, e.lo);
    end
    checks++;
    if (alu_ctl !== ALU_NOOP || alu_req !== 1'b0) begin
      errors++;
      $display("FAIL done_ctl got ctl=%h req=%b exp %h 0", alu_ctl, alu_req, ALU_NOOP);
    end
    alu_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (alu_ctl !== ALU_NOOP || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_idle_ctl got ctl=%h busy=%b exp %h 0", alu_ctl, busy, ALU_NOOP);
    end
  endtask

  // start held through the done cycle is only taken the cycle after
  task automatic test_back_to_back();
    exp_t e;
    exp_t e2;
    int lat;
    issue(32'd1000, 32'd3000, 1'b0);
    wait_done(1, lat);
    e = sb.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo}) begin
      errors++;
      $display("FAIL b2b_first got %h_%h exp %h_%h", hi, lo, e.hi, e.lo);
    end
    rs = 32'hDEAD_BEEF; rt = 32'h0000_0101; is_signed = 1'b1; start = 1'b1;
    sb.push_back(model(rs, rt, 1'b1));
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00 || {hi, lo} !== {e.hi, e.lo}) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b done=%b hi=%h lo=%h exp 0 0 %h %h", busy, done, hi, lo, e.hi, e.lo);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat);
    e2 = sb.pop_front();
    checks++;
    if (lat != e2.lat || {hi, lo} !== {e2.hi, e2.lo}) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d %h_%h exp lat=%0d %h_%h", lat, hi, lo, e2.lat, e2.hi, e2.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t e;
    int lat;
    for (int i = 0; i < 8; i++) begin
      issue($urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_done(1, lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || {hi, lo} !== {e.hi, e.lo}) begin
        errors++;
        $display("FAIL rand%0d got lat=%0d %h_%h exp lat=%0d %h_%h", i, lat, hi, lo, e.lat, e.hi, e.lo);
      end
      @(negedge clk);
    end
  endtask

  // Async reset mid-ITER aborts with no done; next op runs cleanly
  task automatic test_reset_mid();
    exp_t e;
    int lat;
    bit seen;
    issue(32'h0001_2345, 32'h0000_6789, 1'b0);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({busy, done, alu_req, alu_cin} !== 4'b0000 || alu_ctl !== ALU_NOOP ||
        {hi, lo, alu_a, alu_b} !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b req=%b ctl=%h hi=%h lo=%h exp all reset", busy, done, alu_req, alu_ctl, hi, lo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_done got activity=1 exp 0");
    end
    issue(32'd5, 32'd6, 1'b0);
    wait_done(1, lat);
    e = sb.pop_front();
    checks++;
    if (lat != e.lat || {hi, lo} !== {e.hi, e.lo} || lo !== 32'd30) begin
      errors++;
      $display("FAIL reset_then_op got lat=%0d %h_%h exp lat=%0d %h_%h", lat, hi, lo, e.lat, e.hi, e.lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
